main_fsm: RTL and testbench

Multicycle RISC-V main control FSM. It is the producer of the 2-bit ALUOp consumed by aludec, and it sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, jal and beq. It sits in the controller beside aludec; the top-level controller forms PCWrite = PCUpdate | (Branch & Zero).

---
 rtl/riscv_pkg.sv | 46 ++++
 rtl/main_fsm.sv | 145 ++++++++++++++
 tb/tb_main_fsm.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller (main FSM and aludec).
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  // Opcode field values, instr[6:0]
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALUOp: what aludec should make the ALU do
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/main_fsm.sv
// Multicycle RISC-V main control FSM: Moore machine sequencing
// fetch/decode/execute/memory/writeback for lw, sw, R, I, jal, beq.
module main_fsm
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       AdrSrc,
  output logic [1:0] ALUOp,
  output logic [3:0] state_o
);

  state_t state;
  state_t next_state;

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  // Next-state selection; op is only consulted in DECODE and MEMADR
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = FETCH;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      JAL:      next_state = ALUWB;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Output decode from state; during reset all enables are held low and
  // the selects show the FETCH values regardless of the current state
  always_comb begin
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = '0;
    ALUSrcA   = '0;
    ALUSrcB   = '0;
    AdrSrc    = 1'b0;
    ALUOp     = '0;
    if (reset) begin
      ResultSrc = RES_ALURESULT;
      ALUSrcA   = SRCA_PC;
      ALUSrcB   = SRCB_FOUR;
      ALUOp     = ALUOP_ADD;
    end else begin
      case (state)
        FETCH: begin
          IRWrite   = 1'b1;
          PCUpdate  = 1'b1;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALUOP_ADD;
          ResultSrc = RES_ALURESULT;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        MEMADR: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ADD;
        end
        MEMREAD: begin
          ResultSrc = RES_ALUOUT;
          AdrSrc    = 1'b1;
        end
        MEMWB: begin
          ResultSrc = RES_DATA;
          RegWrite  = 1'b1;
        end
        MEMWRITE: begin
          ResultSrc = RES_ALUOUT;
          AdrSrc    = 1'b1;
          MemWrite  = 1'b1;
        end
        EXECUTER: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_WD;
          ALUOp   = ALUOP_FUNCT;
        end
        EXECUTEI: begin
          ALUSrcA = SRCA_RD1;
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_FUNCT;
        end
        ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = 1'b1;
        end
        JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALUOP_ADD;
          ResultSrc = RES_ALUOUT;
          PCUpdate  = 1'b1;
        end
        BEQ: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_WD;
          ALUOp     = ALUOP_SUB;
          ResultSrc = RES_ALUOUT;
          Branch    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: expected per-cycle state/control words are
// queued per instruction and compared cycle by cycle.
module tb_main_fsm;
  import riscv_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_o;

  main_fsm dut (
    .clk(clk), .reset(reset), .op(op),
    .PCUpdate(PCUpdate), .Branch(Branch), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc),
    .ALUOp(ALUOp), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // {PCUpdate,Branch,RegWrite,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,AdrSrc,ALUOp}
  logic [13:0] obs;
  assign obs = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite,
                ResultSrc, ALUSrcA, ALUSrcB, AdrSrc, ALUOp};

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] ctrl;
  } exp_t;

  exp_t q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [13:0] RESET_CTRL = 14'b00000_10_00_10_0_00;

  function automatic logic [13:0] ctrl_of(state_t s);
    case (s)
      FETCH:    return 14'b10001_10_00_10_0_00;
      DECODE:   return 14'b00000_00_01_01_0_00;
      MEMADR:   return 14'b00000_00_10_01_0_00;
      MEMREAD:  return 14'b00000_00_00_00_1_00;
      MEMWB:    return 14'b00100_01_00_00_0_00;
      MEMWRITE: return 14'b00010_00_00_00_1_00;
      EXECUTER: return 14'b00000_00_10_00_0_10;
      EXECUTEI: return 14'b00000_00_10_01_0_10;
      ALUWB:    return 14'b00100_00_00_00_0_00;
      JAL:      return 14'b10000_00_01_10_0_00;
      BEQ:      return 14'b01000_00_10_00_0_01;
      default:  return 14'b00000_00_00_00_0_00;
    endcase
  endfunction

  task automatic push(input state_t s);
    exp_t e;
    e.st   = s;
    e.ctrl = ctrl_of(s);
    q.push_back(e);
  endtask

  task automatic check(input string tag, input exp_t e);
    tests++;
    assert (state_o === e.st) else begin
      fails++;
      $error("FAIL %s state got %0d expected %0d", tag, state_o, e.st);
    end
    tests++;
    assert (obs === e.ctrl) else begin
      fails++;
      $error("FAIL %s ctrl@%0d got %b expected %b", tag, e.st, obs, e.ctrl);
    end
  endtask

  // Compare one queued entry per cycle; ends one edge past the last entry
  task automatic drain(input string tag);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(tag, e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    op    = OP_LW;

    // Reset held two cycles
    e.st = FETCH; e.ctrl = RESET_CTRL;
    @(posedge clk); #1; check("reset1", e);
    @(posedge clk); #1; check("reset2", e);
    reset = 1'b0;
    #1;

    // lw: 5 cycles
    push(FETCH); push(DECODE); push(MEMADR); push(MEMREAD); push(MEMWB);
    drain("lw");

    // sw: 4 cycles
    op = OP_SW;
    push(FETCH); push(DECODE); push(MEMADR); push(MEMWRITE);
    drain("sw");

    // R-type then I-type: 4 cycles each
    op = OP_R;
    push(FETCH); push(DECODE); push(EXECUTER); push(ALUWB);
    drain("rtype");
    op = OP_I;
    push(FETCH); push(DECODE); push(EXECUTEI); push(ALUWB);
    drain("itype");

    // beq: 3 cycles
    op = OP_BEQ;
    push(FETCH); push(DECODE); push(BEQ);
    drain("beq");

    // jal: 4 cycles
    op = OP_JAL;
    push(FETCH); push(DECODE); push(JAL); push(ALUWB);
    drain("jal");

    // Illegal opcode: skipped after DECODE
    op = 7'b1111111;
    push(FETCH); push(DECODE);
    drain("illegal");

    // lw interrupted by reset during MEMREAD
    op = OP_LW;
    push(FETCH); push(DECODE); push(MEMADR);
    drain("lw_pre");
    reset = 1'b1;
    #1;
    e.st = MEMREAD; e.ctrl = RESET_CTRL;
    check("rst_in_memread", e);
    @(posedge clk); #1;
    e.st = FETCH; e.ctrl = RESET_CTRL;
    check("rst_after_memread", e);
    reset = 1'b0;
    #1;

    // Normal operation resumes with a full FETCH
    op = OP_R;
    push(FETCH); push(DECODE); push(EXECUTER); push(ALUWB); push(FETCH);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
